// File: rtl/stage_counter_if.sv
// Handshake bundle for stage_counter: advance enable in, stage number and status out.
// The onehot_o signal exists only when STAGE_COUNTER_ONEHOT_EN is defined.
interface stage_counter_if #(
    parameter int WIDTH     = 3,
    parameter int LAST      = 5,
    parameter int CNT_WIDTH = 32
);
    logic                 en;
    logic [WIDTH-1:0]     out;
    logic                 last_o;
    logic                 wrap_o;
    logic [CNT_WIDTH-1:0] cycles_o;
`ifdef STAGE_COUNTER_ONEHOT_EN
    logic [LAST:0]        onehot_o;

    modport master (output en, input out, last_o, wrap_o, cycles_o, onehot_o);
    modport slave  (input en, output out, last_o, wrap_o, cycles_o, onehot_o);
`else
    modport master (output en, input out, last_o, wrap_o, cycles_o);
    modport slave  (input en, output out, last_o, wrap_o, cycles_o);
`endif
endinterface

// File: rtl/stage_counter.sv
// Free-running instruction-phase sequencer (0 idle, then FIRST..LAST repeating) with wrap pulse
// and completed-cycle counter. Define STAGE_COUNTER_ONEHOT_EN to add the registered onehot_o output.
module stage_counter #(
    parameter int WIDTH     = 3,
    parameter int FIRST     = 1,
    parameter int LAST      = 5,
    parameter int CNT_WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    stage_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] FIRST_S = WIDTH'(FIRST);
    localparam logic [WIDTH-1:0] LAST_S  = WIDTH'(LAST);

    logic [WIDTH-1:0]     stage_q;
    logic                 wrap_q;
    logic [CNT_WIDTH-1:0] cycles_q;

    logic [WIDTH-1:0]     stage_d;
    logic                 wrap_d;
    logic [CNT_WIDTH-1:0] cycles_d;

    // NOTE: every output of always_comb is given a default first so no path leaves it unassigned (no latch).
    always_comb begin
        stage_d  = stage_q;
        wrap_d   = 1'b0;
        cycles_d = cycles_q;
        if (bus.en) begin
            if (stage_q == '0) begin
                stage_d = FIRST_S;
            end else if (stage_q >= FIRST_S && stage_q < LAST_S) begin
                stage_d = stage_q + WIDTH'(1);
            end else if (stage_q == LAST_S) begin
                stage_d  = FIRST_S;
                wrap_d   = 1'b1;
                cycles_d = cycles_q + CNT_WIDTH'(1);
            end else begin
                // Out-of-range stage: fall back to FIRST without counting a cycle.
                stage_d = FIRST_S;
            end
        end
    end

`ifdef STAGE_COUNTER_ONEHOT_EN
    logic [LAST:0] onehot_q;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_q  <= '0;
            wrap_q   <= 1'b0;
            cycles_q <= '0;
`ifdef STAGE_COUNTER_ONEHOT_EN
            onehot_q <= (LAST+1)'(1);
`endif
        end else begin
            stage_q  <= stage_d;
            wrap_q   <= wrap_d;
            cycles_q <= cycles_d;
`ifdef STAGE_COUNTER_ONEHOT_EN
            onehot_q <= (LAST+1)'(1) << stage_d;
`endif
        end
    end

    assign bus.out      = stage_q;
    assign bus.last_o   = (stage_q == LAST_S);
    assign bus.wrap_o   = wrap_q;
    assign bus.cycles_o = cycles_q;
`ifdef STAGE_COUNTER_ONEHOT_EN
    assign bus.onehot_o = onehot_q;
`endif

endmodule

// File: tb/tb_stage_counter.sv
// Directed self-checking bench for stage_counter: default instance plus a CNT_WIDTH=2 instance
// for counter wrap. Build with STAGE_COUNTER_ONEHOT_EN to also check onehot_o.
module tb_stage_counter;
    logic clk;
    logic reset;
    logic reset2;
    int   n_checks;
    int   n_fails;

    stage_counter_if #(.WIDTH(3), .LAST(5), .CNT_WIDTH(32)) bus ();
    stage_counter_if #(.WIDTH(3), .LAST(5), .CNT_WIDTH(2))  bus2 ();

    stage_counter #(.WIDTH(3), .FIRST(1), .LAST(5), .CNT_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    stage_counter #(.WIDTH(3), .FIRST(1), .LAST(5), .CNT_WIDTH(2)) dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Sample the default instance against a hand-computed stage/last/wrap/cycles tuple.
    task automatic check_state(input string tag, input int exp_out, input bit exp_last,
                               input bit exp_wrap, input int exp_cycles);
        check({tag, " out"},    32'(bus.out),      32'(exp_out));
        check({tag, " last"},   32'(bus.last_o),   32'(exp_last));
        check({tag, " wrap"},   32'(bus.wrap_o),   32'(exp_wrap));
        check({tag, " cycles"}, bus.cycles_o,      32'(exp_cycles));
`ifdef STAGE_COUNTER_ONEHOT_EN
        check({tag, " onehot"}, 32'(bus.onehot_o), 32'(1) << exp_out);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b0;
        reset2   = 1'b0;
        bus.en   = 1'b1;
        bus2.en  = 1'b1;

        // Reset held two clocks with en high.
        step();
        step();
        check_state("reset", 0, 0, 0, 0);
        reset = 1'b1;

        step(); check_state("run1", 1, 0, 0, 0);
        step(); check_state("run2", 2, 0, 0, 0);
        step(); check_state("run3", 3, 0, 0, 0);
        step(); check_state("run4", 4, 0, 0, 0);
        step(); check_state("run5", 5, 1, 0, 0);
        step(); check_state("wrap1", 1, 0, 1, 1);
        step(); check_state("run2b", 2, 0, 0, 1);
        step(); check_state("run3b", 3, 0, 0, 1);

        // Hold at 3 for four clocks.
        bus.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); check_state("hold3", 3, 0, 0, 1);
        end
        bus.en = 1'b1;
        step(); check_state("resume4", 4, 0, 0, 1);
        step(); check_state("run5c", 5, 1, 0, 1);

        // Hold at LAST: last_o stays high, no wrap.
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); check_state("hold5", 5, 1, 0, 1);
        end
        bus.en = 1'b1;
        step(); check_state("wrap2", 1, 0, 1, 2);

        // en dropping right after a wrap clears wrap_o.
        bus.en = 1'b0;
        step(); check_state("wrapclr", 1, 0, 0, 2);
        bus.en = 1'b1;
        step(); check_state("run2d", 2, 0, 0, 2);
        step(); check_state("run3d", 3, 0, 0, 2);
        step(); check_state("run4d", 4, 0, 0, 2);

        // Mid-cycle reset at stage 4.
        reset = 1'b0;
        step(); check_state("midreset", 0, 0, 0, 0);
        reset = 1'b1;
        step(); check_state("postreset", 1, 0, 0, 0);

        // Recovery from an illegal stage value.
        force dut.stage_q = 3'd7;
        #1;
        release dut.stage_q;
        #1;
        check("forced out", 32'(bus.out), 32'd7);
        check("forced last", 32'(bus.last_o), 32'd0);
        step(); check_state("recover", 1, 0, 0, 0);
        step(); check_state("recover2", 2, 0, 0, 0);

        // Two-bit cycle counter wraps modulo 4.
        reset2 = 1'b1;
        step();
        check("cnt2 first", 32'(bus2.out), 32'd1);
        for (int k = 0; k < 5; k++) begin
            for (int s = 0; s < 4; s++) begin
                step();
                check("cnt2 nowrap", 32'(bus2.wrap_o), 32'd0);
            end
            step();
            check("cnt2 out", 32'(bus2.out), 32'd1);
            check("cnt2 wrap", 32'(bus2.wrap_o), 32'd1);
            check("cnt2 cycles", 32'(bus2.cycles_o), 32'((k + 1) % 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/stage_counter.md
# stage_counter

Free-running stage sequencer for the multi-cycle CPU control path. It produces the current instruction-phase number: 1 fetch, 2 decode, 3 execute, 4 memory, 5 write-back. The control FSM compares that number against constants to drive the datapath strobes. It also reports the final stage and counts completed instruction cycles.

## Interface
Parameters:
- WIDTH, 3: width of the stage number output.
- FIRST, 1: first stage of each instruction cycle.
- LAST, 5: final stage; must satisfy 1 ≤ FIRST ≤ LAST < 2^WIDTH.
- CNT_WIDTH, 32: width of the completed-cycle counter.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- reset  in  1  one clock; reset is synchronous and active-low (0 = reset asserted).
- en  in  1  advance enable; 0 holds all state.
- out  out  WIDTH  current stage number.
- last_o  out  1  high while out == LAST (combinational from out).
- wrap_o  out  1  registered one-cycle pulse, high in the cycle after out advanced LAST→FIRST.
- cycles_o  out  CNT_WIDTH  number of LAST→FIRST transitions since reset.

## Operation
- Stage 0 is the idle state. It occurs only after reset and is never re-entered during normal running.
- Each rising clk edge, in priority order:
  - reset == 0: out=0, wrap_o=0, cycles_o=0, and the one-hot output if compiled in = bit 0 only. Reset overrides en.
  - en == 0: all registers hold, except wrap_o, which clears to 0.
  - out == 0: out=FIRST, wrap_o=0.
  - FIRST ≤ out < LAST: out=out+1, wrap_o=0.
  - out == LAST: out=FIRST, wrap_o=1, cycles_o=cycles_o+1.
  - Any other value (out > LAST, or 0 < out < FIRST): out=FIRST, wrap_o=0, cycles_o unchanged. This is the recovery path.
- The sequence with defaults is 0,1,2,3,4,5,1,2,…
- cycles_o wraps modulo 2^CNT_WIDTH. All-ones + 1 gives 0, with no saturation and no flag.
- last_o = (out == LAST). It is purely combinational and is 0 during stage 0.

## Timing
- Stage latency: out changes exactly one clk after a qualifying edge. There is no combinational path from en to out.
- After reset is released, the first enabled edge gives out=FIRST. With continuous en, a full cycle takes LAST−FIRST+1 clocks (5 by default).
- wrap_o and the cycles_o increment become visible in the same cycle out becomes FIRST.
- A reset asserted mid-cycle takes effect at the next edge, regardless of the current stage or en.
- If en drops while out == LAST, the counter stays at LAST and last_o stays high. The wrap happens on the next enabled edge.
- Reset values: out=0, last_o=0, wrap_o=0, cycles_o=0, onehot_o=1.

## Configuration
- Macro: STAGE_COUNTER_ONEHOT_EN.
- Defined: adds output port onehot_o, width LAST+1, registered. Bit k is high exactly when out == k. It is updated on the same edges as out, and reset value is bit 0 set. On the recovery path it shows bit FIRST.
- Undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Reset then run: hold reset=0 for 2 clocks with en=1, then release. Require out = 0,1,2,3,4,5,1 on successive edges. Require last_o=1 only at out=5, wrap_o=1 only at the second out=1, and cycles_o=1 after it.
- Hold: with en=0 at out=3 for 4 clocks, out stays 3. Re-asserting en gives 4. Holding at out=5 keeps last_o=1, wrap_o=0, cycles_o unchanged.
- Mid-cycle reset: set reset=0 while out=4 and en=1. The next edge gives out=0, cycles_o=0, wrap_o=0.
- Counter wrap: with CNT_WIDTH=2, run 5 full cycles. cycles_o reads 1,2,3,0,1.
- Recovery: force out=7 with defaults. The next enabled edge gives out=1, wrap_o=0, cycles_o unchanged.
- With STAGE_COUNTER_ONEHOT_EN: across the sequence 0..5,1, onehot_o = 000001, 000010, 000100, 001000, 010000, 100000, 000010 (bit 0 = LSB).
